// File: rtl/filter_pkg.sv
// ---------------------------------------------------------------------------
// filter_pkg
// Shared constants for the pixel filter mode controller: keypad command
// codes, filter mode codes and the commit state machine encoding.
// ---------------------------------------------------------------------------
package filter_pkg;

    // Keypad command codes; digits 0..9 select a filter directly.
    localparam logic [4:0] KEY_NEXT   = 5'h0A;
    localparam logic [4:0] KEY_PREV   = 5'h0B;
    localparam logic [4:0] KEY_AUTO   = 5'h0C;
    localparam logic [4:0] KEY_BYPASS = 5'h0D;

    // Filter mode codes as seen by the filter mux and the display.
    localparam logic [4:0] MODE_GRAY    = 5'h00;
    localparam logic [4:0] MODE_SINCITY = 5'h09;
    localparam logic [4:0] MODE_BYPASS  = 5'h0A;

    // IDLE: committed mode is current. PEND: a new mode waits for frame_start.
    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } mode_state_t;

endpackage

// File: rtl/key_edge_detect.sv
// ---------------------------------------------------------------------------
// key_edge_detect
// Turns the keypad key-present level into a single acceptance per press.
// A press is accepted in the cycle where key_valid is high and was low in
// the previous cycle, so a held key is accepted exactly once.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   key_valid  in   key-present level
//   key_data   in   key code, valid while key_valid is high
//   key_accept out  high in the cycle a new press is accepted
//   key_code   out  key code belonging to key_accept
// ---------------------------------------------------------------------------
module key_edge_detect (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [4:0] key_data,
    output logic       key_accept,
    output logic [4:0] key_code
);

    logic key_valid_q;

    // Remember last cycle's key_valid level so a rising edge can be spotted.
    // Clearing it on reset means a key already held during reset is still
    // accepted once reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_valid_q <= 1'b0;
        end else begin
            key_valid_q <= key_valid;
        end
    end

    assign key_accept = key_valid & ~key_valid_q;
    assign key_code   = key_data;

endmodule

// File: rtl/filter_mode_ctrl.sv
// ---------------------------------------------------------------------------
// filter_mode_ctrl
// Keypad-driven mode controller for the pixel filter selector. Key presses
// choose a target filter mode; the change is held as pending and committed
// only on frame_start so that no frame is rendered with mixed filters.
// Also supports NEXT/PREV stepping, a bypass key and an auto-cycle slideshow
// that advances one filter every AUTO_FRAMES frames.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   key_valid    in   keypad key-present level (may be held)
//   key_data     in   key code, valid while key_valid is high
//   frame_start  in   one-cycle pulse at the start of each frame
//   bcd_data     out  committed mode code (filter mux / display)
//   pend_mode    out  mode waiting for commit
//   pending      out  a commit is waiting for frame_start
//   auto_on      out  auto-cycle slideshow enabled
//   mode_changed out  one-cycle pulse with the first cycle of new bcd_data
// ---------------------------------------------------------------------------
module filter_mode_ctrl
    import filter_pkg::*;
#(
    parameter int         NUM_MODES   = 11,
    parameter int         AUTO_FRAMES = 60,
    parameter logic [4:0] RESET_MODE  = 5'h0A
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [4:0] key_data,
    input  logic       frame_start,
    output logic [4:0] bcd_data,
    output logic [4:0] pend_mode,
    output logic       pending,
    output logic       auto_on,
    output logic       mode_changed
);

    localparam int CNT_W = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AUTO_FRAMES - 1);
    localparam logic [4:0] MODE_LAST = 5'(NUM_MODES - 1);

    mode_state_t      state, state_n;
    logic [4:0]       bcd_n, pend_n;
    logic             auto_n, changed_n;
    logic [CNT_W-1:0] frame_cnt, cnt_n;

    logic             key_accept;
    logic [4:0]       key_code;
    logic [4:0]       base, target, auto_next;
    logic             has_target, auto_off, auto_toggle;

    key_edge_detect u_key_edge (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_data   (key_data),
        .key_accept (key_accept),
        .key_code   (key_code)
    );

    // pending is exactly the PEND state bit, so it is a flop output.
    assign pending = (state == PEND);

    // Decode the accepted key into a target mode. NEXT/PREV step relative to
    // the pending mode when one exists, so repeated presses before a frame
    // boundary accumulate instead of all starting from the committed mode.
    always_comb begin
        base        = pending ? pend_mode : bcd_data;
        target      = base;
        has_target  = 1'b0;
        auto_off    = 1'b0;
        auto_toggle = 1'b0;
        if (key_accept) begin
            case (key_code)
                KEY_NEXT: begin
                    target     = (base >= MODE_LAST) ? MODE_GRAY : base + 5'd1;
                    has_target = 1'b1;
                end
                KEY_PREV: begin
                    target     = (base == MODE_GRAY) ? MODE_LAST : base - 5'd1;
                    has_target = 1'b1;
                end
                KEY_AUTO: begin
                    auto_toggle = 1'b1;
                end
                KEY_BYPASS: begin
                    target     = MODE_BYPASS;
                    has_target = 1'b1;
                    auto_off   = 1'b1;
                end
                default: begin
                    if (key_code <= MODE_SINCITY) begin
                        target     = key_code;
                        has_target = 1'b1;
                        auto_off   = 1'b1;
                    end
                end
            endcase
        end
    end

    // Next-state logic. A key with a target always takes priority over the
    // auto-cycle step; when it coincides with frame_start its target is
    // committed at once. A key whose target equals the committed mode
    // cancels any pending change rather than committing a no-op.
    always_comb begin
        state_n   = state;
        bcd_n     = bcd_data;
        pend_n    = pend_mode;
        auto_n    = auto_on;
        cnt_n     = frame_cnt;
        changed_n = 1'b0;
        auto_next = (bcd_data >= MODE_SINCITY) ? MODE_GRAY : bcd_data + 5'd1;

        if (auto_toggle) begin
            auto_n = ~auto_on;
            cnt_n  = '0;
        end
        if (auto_off) begin
            auto_n = 1'b0;
        end

        if (has_target) begin
            if (frame_start) begin
                cnt_n   = '0;
                pend_n  = target;
                state_n = IDLE;
                if (target != bcd_data) begin
                    bcd_n     = target;
                    changed_n = 1'b1;
                end
            end else if (target != bcd_data) begin
                pend_n  = target;
                state_n = PEND;
            end else begin
                pend_n  = bcd_data;
                state_n = IDLE;
            end
        end else if (frame_start) begin
            if (state == PEND) begin
                bcd_n     = pend_mode;
                changed_n = 1'b1;
                state_n   = IDLE;
            end else if (auto_on && !auto_toggle) begin
                if (frame_cnt == CNT_LAST) begin
                    cnt_n     = '0;
                    bcd_n     = auto_next;
                    pend_n    = auto_next;
                    changed_n = 1'b1;
                end else begin
                    cnt_n = frame_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Register every output and the frame counter; reset returns to the
    // bypass mode with nothing pending and the slideshow off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            bcd_data     <= RESET_MODE;
            pend_mode    <= RESET_MODE;
            auto_on      <= 1'b0;
            frame_cnt    <= '0;
            mode_changed <= 1'b0;
        end else begin
            state        <= state_n;
            bcd_data     <= bcd_n;
            pend_mode    <= pend_n;
            auto_on      <= auto_n;
            frame_cnt    <= cnt_n;
            mode_changed <= changed_n;
        end
    end

endmodule

// File: tb/tb_filter_mode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_filter_mode_ctrl
// Self-checking bench for filter_mode_ctrl with a short auto-cycle period.
// A behavioural reference model tracks the committed mode, the pending mode
// and the slideshow frame count and is compared against the DUT every cycle.
// ---------------------------------------------------------------------------
module tb_filter_mode_ctrl;
    import filter_pkg::*;

    localparam int NUM   = 11;
    localparam int AUTOF = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [4:0] key_data = 5'h00;
    logic       frame_start = 1'b0;
    logic [4:0] bcd_data, pend_mode;
    logic       pending, auto_on, mode_changed;

    int checkCount = 0;
    int passCount  = 0;

    int mBcd, mPend, mPending, mAuto, mCnt, mPrevKv, mChanged;

    filter_mode_ctrl #(
        .NUM_MODES   (NUM),
        .AUTO_FRAMES (AUTOF),
        .RESET_MODE  (5'h0A)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_valid    (key_valid),
        .key_data     (key_data),
        .frame_start  (frame_start),
        .bcd_data     (bcd_data),
        .pend_mode    (pend_mode),
        .pending      (pending),
        .auto_on      (auto_on),
        .mode_changed (mode_changed)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts the check and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %0h expected %0h (t=%0t)",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mBcd = 10; mPend = 10; mPending = 0; mAuto = 0;
        mCnt = 0; mPrevKv = 0; mChanged = 0;
    endtask

    // Reference model: one clock edge worth of the mode-selection rules.
    task automatic modelStep(input int kv, input int kd, input int fs);
        int accept, base, target, hasT, autoKey;
        accept   = (kv != 0 && mPrevKv == 0);
        mPrevKv  = kv;
        mChanged = 0;
        hasT     = 0;
        autoKey  = 0;
        target   = 0;
        base     = mPending ? mPend : mBcd;
        if (accept) begin
            if (kd <= 9) begin
                target = kd; hasT = 1; mAuto = 0;
            end else if (kd == 10) begin
                target = (base + 1) % NUM; hasT = 1;
            end else if (kd == 11) begin
                target = (base + NUM - 1) % NUM; hasT = 1;
            end else if (kd == 12) begin
                autoKey = 1; mAuto = !mAuto; mCnt = 0;
            end else if (kd == 13) begin
                target = 10; hasT = 1; mAuto = 0;
            end
        end
        if (hasT) begin
            if (fs) begin
                mCnt = 0;
                if (target != mBcd) begin
                    mBcd = target; mChanged = 1;
                end
                mPending = 0; mPend = mBcd;
            end else if (target != mBcd) begin
                mPend = target; mPending = 1;
            end else begin
                mPending = 0; mPend = mBcd;
            end
        end else if (fs) begin
            if (mPending) begin
                mBcd = mPend; mPending = 0; mChanged = 1;
            end else if (mAuto && !autoKey) begin
                mCnt++;
                if (mCnt == AUTOF) begin
                    mCnt = 0;
                    mBcd = (mBcd >= 9) ? 0 : mBcd + 1;
                    mPend = mBcd;
                    mChanged = 1;
                end
            end
        end
    endtask

    task automatic compareAll(input string tag);
        checkOutput({tag, ".bcd"}, 32'(bcd_data), 32'(mBcd));
        checkOutput({tag, ".pend"}, 32'(pend_mode), 32'(mPend));
        checkOutput({tag, ".pending"}, 32'(pending), 32'(mPending));
        checkOutput({tag, ".auto"}, 32'(auto_on), 32'(mAuto));
        checkOutput({tag, ".changed"}, 32'(mode_changed), 32'(mChanged));
    endtask

    // Drives one cycle of inputs; called #1 after a rising edge.
    task automatic applyStimulus(input logic kv, input logic [4:0] kd, input logic fs);
        key_valid   = kv;
        key_data    = kd;
        frame_start = fs;
        @(negedge clk);
        compareAll("cyc");
        @(posedge clk);
        modelStep(int'(kv), int'(kd), int'(fs));
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 5'h00, 1'b0);
    endtask

    task automatic pressKey(input logic [4:0] code);
        applyStimulus(1'b1, code, 1'b0);
        applyStimulus(1'b0, 5'h00, 1'b0);
    endtask

    task automatic frame();
        applyStimulus(1'b0, 5'h00, 1'b1);
        idle(2);
    endtask

    task automatic doReset();
        rst = 1'b1;
        key_valid = 1'b0;
        frame_start = 1'b0;
        modelReset();
        #1;
        checkOutput("rst.bcd", 32'(bcd_data), 32'h0A);
        checkOutput("rst.pending", 32'(pending), 32'h0);
        checkOutput("rst.auto", 32'(auto_on), 32'h0);
        checkOutput("rst.changed", 32'(mode_changed), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic       kv;
        logic [4:0] kd;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("init.bcd", 32'(bcd_data), 32'h0A);
        checkOutput("init.pend", 32'(pend_mode), 32'h0A);
        rst = 1'b0;
        idle(2);

        $display("[TB] digit commit");
        pressKey(5'h03);
        checkOutput("d3.pending", 32'(pending), 32'h1);
        idle(18);
        checkOutput("d3.hold", 32'(bcd_data), 32'h0A);
        applyStimulus(1'b0, 5'h00, 1'b1);
        checkOutput("d3.bcd", 32'(bcd_data), 32'h03);
        checkOutput("d3.pulse", 32'(mode_changed), 32'h1);
        idle(1);
        checkOutput("d3.pulse_end", 32'(mode_changed), 32'h0);

        $display("[TB] held key and last-wins");
        for (int i = 0; i < 50; i++) applyStimulus(1'b1, 5'h07, 1'b0);
        idle(1);
        checkOutput("held.pend", 32'(pend_mode), 32'h07);
        pressKey(5'h02);
        pressKey(5'h05);
        frame();
        checkOutput("last.bcd", 32'(bcd_data), 32'h05);

        $display("[TB] wrap");
        pressKey(KEY_BYPASS);
        frame();
        pressKey(KEY_NEXT);
        frame();
        checkOutput("next.wrap", 32'(bcd_data), 32'h00);
        pressKey(KEY_PREV);
        frame();
        checkOutput("prev.wrap", 32'(bcd_data), 32'h0A);

        $display("[TB] auto cycle");
        pressKey(KEY_AUTO);
        checkOutput("auto.on", 32'(auto_on), 32'h1);
        for (int i = 0; i < AUTOF; i++) frame();
        checkOutput("auto.step0", 32'(bcd_data), 32'h00);
        for (int i = 0; i < AUTOF * 9; i++) frame();
        checkOutput("auto.step9", 32'(bcd_data), 32'h09);
        for (int i = 0; i < AUTOF; i++) frame();
        checkOutput("auto.wrap", 32'(bcd_data), 32'h00);
        pressKey(5'h04);
        checkOutput("auto.off", 32'(auto_on), 32'h0);
        frame();
        checkOutput("auto.digit", 32'(bcd_data), 32'h04);

        $display("[TB] collisions");
        pressKey(5'h01);
        frame();
        applyStimulus(1'b1, 5'h06, 1'b1);
        checkOutput("coll.bcd", 32'(bcd_data), 32'h06);
        checkOutput("coll.pulse", 32'(mode_changed), 32'h1);
        idle(1);
        pressKey(KEY_AUTO);
        frame();
        frame();
        applyStimulus(1'b1, KEY_NEXT, 1'b1);
        checkOutput("acoll.bcd", 32'(bcd_data), 32'h07);
        idle(1);
        frame();
        frame();
        checkOutput("acoll.cnt_clear", 32'(bcd_data), 32'h07);
        frame();
        checkOutput("acoll.step", 32'(bcd_data), 32'h08);
        pressKey(KEY_AUTO);

        $display("[TB] reset mid-pend");
        pressKey(5'h02);
        checkOutput("rpend.pending", 32'(pending), 32'h1);
        doReset();
        idle(1);
        frame();
        checkOutput("rpend.nocommit", 32'(bcd_data), 32'h0A);

        $display("[TB] random stimulus");
        kv = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (kv) kv = ($urandom_range(0, 2) != 0);
            else    kv = ($urandom_range(0, 3) == 0);
            kd = 5'($urandom_range(0, 15));
            applyStimulus(kv, kd, ($urandom_range(0, 5) == 0));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/filter_mode_ctrl.md
Name: filter_mode_ctrl

Overview:
- Mode controller for the pixel filter selector.
- Turns keypad events into the 5-bit filter mode code (bcd_data) that drives the filter mux and the 7-segment display.
- Mode changes are committed only at frame boundaries, so no frame is rendered with mixed filters.
- Adds NEXT/PREV stepping, a bypass key and a timed auto-cycle slideshow.

Parameters:
- NUM_MODES, 11: valid mode codes 0..NUM_MODES-1; codes 0-9 are filters, code 10 (5'h0A) is bypass/pass-through.
- AUTO_FRAMES, 60: frames per step in auto-cycle.
- RESET_MODE, 5'h0A: mode loaded on reset.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- key_valid  in  1  keypad key-present level; may stay high for many cycles
- key_data  in  5  key code, valid while key_valid=1
- frame_start  in  1  one-cycle pulse at start of each frame (vsync-derived)
- bcd_data  out  5  committed mode; feeds filter mux and display
- pend_mode  out  5  mode waiting for commit
- pending  out  1  a commit is waiting for frame_start
- auto_on  out  1  auto-cycle enabled
- mode_changed  out  1  one-cycle pulse, coincident with the first cycle of new bcd_data

Behaviour:
- Reset (async, rst=1), all outputs registered:
  - bcd_data=pend_mode=RESET_MODE
  - pending=0, auto_on=0, mode_changed=0
  - frame counter=0, key_valid history register=0
- Key acceptance:
  - A key is accepted on the cycle where key_valid=1 and the registered previous key_valid=0.
  - key_data is sampled in that cycle.
  - Holding key_valid high yields exactly one acceptance.
- Decode (base = pend_mode if pending else bcd_data):
  - 5'h00-5'h09: target = code; auto_on<=0.
  - 5'h0A NEXT: target = base+1; wraps NUM_MODES-1 -> 0.
  - 5'h0B PREV: target = base-1; wraps 0 -> NUM_MODES-1.
  - 5'h0C AUTO: toggles auto_on, clears frame counter, no target.
  - 5'h0D BYPASS: target = 5'h0A; auto_on<=0.
  - All other codes are ignored.
- FSM:
  - IDLE: an accepted target != bcd_data sets pend_mode=target, pending=1 -> PEND. A target equal to bcd_data is a no-op.
  - PEND:
    - An accepted target overwrites pend_mode (last key wins).
    - A target equal to bcd_data cancels: pending=0, pend_mode=bcd_data -> IDLE.
    - On frame_start: bcd_data<=pend_mode, pending<=0, mode_changed=1 for one cycle -> IDLE.
    - Commit latency: new bcd_data visible the cycle after frame_start.
- Simultaneous key accept and frame_start (either state): the key's effective target is committed at that edge. If it equals bcd_data, no commit and no pulse.
- Auto-cycle:
  - Frame counter increments on frame_start while auto_on=1 and pending=0.
  - On frame_start with counter=AUTO_FRAMES-1: counter<=0, bcd_data<=auto_next(bcd_data), mode_changed=1.
  - auto_next cycles filters only: 9 -> 0; bypass (or any code >= 9) -> 0.
  - A key accepted in the same cycle as an auto step wins; the auto step is dropped and the counter clears.
  - Counter width = clog2(AUTO_FRAMES).
- Mode 8 (edge detect) is treated like any other mode; edge-engine gating stays downstream.
- bcd_data never leaves 0..NUM_MODES-1.

Decomposition:
- Shared package filter_pkg holds:
  - key-code constants KEY_NEXT=5'h0A, KEY_PREV=5'h0B, KEY_AUTO=5'h0C, KEY_BYPASS=5'h0D
  - MODE_GRAY=0 .. MODE_SINCITY=9, MODE_BYPASS=5'h0A
  - FSM state enum {IDLE, PEND}
- One sub-module: key_edge_detect (registered rising-edge pulse plus sampled code).
- Wrap arithmetic and auto counter stay inline.

Test Plan:
- Reset: rst=1 mid-PEND with pending=1 -> immediately bcd_data=5'h0A, pending=0, auto_on=0. After release, no commit on the next frame_start.
- Digit commit: key 5'h03 accepted, frame_start 20 cycles later -> pending=1 and bcd_data=5'h0A until frame_start; next cycle bcd_data=3, mode_changed=1 for exactly one cycle.
- Held/last-wins: key_valid high 50 cycles with 5'h07 -> one acceptance. Then keys 5'h02, 5'h05 before frame_start -> commits 5, single pulse.
- Wrap: from bcd_data=5'h0A, NEXT -> commits 0. From 0, PREV -> commits 5'h0A.
- Auto (AUTO_FRAMES=3): start from bypass, press 5'h0C -> bcd_data goes 0, 1, 2 on every 3rd frame_start. From 9 it wraps to 0. Digit key 5'h04 -> auto_on=0, commits 4.
- Collision: key 5'h06 in the same cycle as frame_start while IDLE at mode 1 -> bcd_data=6 next cycle, one mode_changed. Same collision on an auto-step frame -> key wins, counter=0.
